exec_pipe: RTL

EXEC_PIPE -- requirements
Module: exec_pipe

---
 rtl/exec_pipe_if.sv | 50 +++++
 rtl/exec_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_pipe_if.sv
// ID/EX operand bundle into the execute stage and the EX/MEM register out.
// master drives the ID/EX side; slave is the execute stage.
interface exec_pipe_if #(
  parameter int N  = 32,
  parameter int RW = 4
);
  logic            en;
  logic            flush;
  logic            validIn;
  logic [N-1:0]    rd1;
  logic [N-1:0]    rd2;
  logic [N-1:0]    rd3;
  logic [N-1:0]    pc;
  logic [N-1:0]    imm;
  logic [N-1:0]    aluOutFwd;
  logic [N-1:0]    resultFwd;
  logic [3:0]      aluControl;
  logic [3:0]      ctrlIn;
  logic [3*RW-1:0] regsIn;
  logic            immSrc;
  logic [1:0]      Fa;
  logic [1:0]      Fb;
  logic            busy;
  logic            exmValid;
  logic [N-1:0]    exmResult;
  logic [3:0]      exmFlags;
  logic [3:0]      exmCtrl;
  logic [3*RW-1:0] exmRegs;
  logic [N-1:0]    exmRd3;

  modport master (
    output en, flush, validIn,
    output rd1, rd2, rd3, pc, imm,
    output aluOutFwd, resultFwd,
    output aluControl, ctrlIn, regsIn,
    output immSrc, Fa, Fb,
    input  busy, exmValid, exmResult,
    input  exmFlags, exmCtrl, exmRegs, exmRd3
  );

  modport slave (
    input  en, flush, validIn,
    input  rd1, rd2, rd3, pc, imm,
    input  aluOutFwd, resultFwd,
    input  aluControl, ctrlIn, regsIn,
    input  immSrc, Fa, Fb,
    output busy, exmValid, exmResult,
    output exmFlags, exmCtrl, exmRegs, exmRd3
  );
endinterface

// File: rtl/exec_pipe.sv
// Execute stage: forwarding, ALU, EX/MEM register.
// Define EXEC_MUL_EN for the iterative multiplier (op 8).
module exec_pipe #(
  parameter int N  = 32,
  parameter int RW = 4
) (
  input logic        clk,
  input logic        rst,
  exec_pipe_if.slave bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic [N-1:0]  w_op1;
  logic [N-1:0]  w_op2;
  logic [N-1:0]  w_res;
  logic [N:0]    w_add;
  logic [N:0]    w_sub;
  logic [SW-1:0] w_sh;
  logic [3:0]    w_flags;
  logic          w_c;
  logic          w_v;

  always_comb begin
    unique case (bus.Fa)
      2'b01:   w_a = bus.aluOutFwd;
      2'b10:   w_a = bus.resultFwd;
      default: w_a = bus.rd1;
    endcase
  end

  always_comb begin
    unique case (bus.Fb)
      2'b01:   w_b = bus.aluOutFwd;
      2'b10:   w_b = bus.resultFwd;
      default: w_b = bus.rd2;
    endcase
  end

  assign w_op1 = bus.ctrlIn[3] ? bus.pc : w_a;
  assign w_op2 = bus.immSrc ? bus.imm : w_b;
  assign w_sh  = w_op2[SW-1:0];
  assign w_add = {1'b0, w_op1} + {1'b0, w_op2};
  assign w_sub = {1'b0, w_op1} + {1'b0, ~w_op2} + (N+1)'(1);

  // op 8 lands in default: the multiplier owns it when present
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.aluControl)
      4'd0: begin
        w_res = w_add[N-1:0];
        w_c   = w_add[N];
        w_v   = (w_op1[N-1] == w_op2[N-1]) &&
                (w_add[N-1] != w_op1[N-1]);
      end
      4'd1: begin
        w_res = w_sub[N-1:0];
        w_c   = w_sub[N];
        w_v   = (w_op1[N-1] != w_op2[N-1]) &&
                (w_sub[N-1] != w_op1[N-1]);
      end
      4'd2:    w_res = w_op1 & w_op2;
      4'd3:    w_res = w_op1 | w_op2;
      4'd4:    w_res = w_op1 ^ w_op2;
      4'd5:    w_res = w_op1 << w_sh;
      4'd6:    w_res = w_op1 >> w_sh;
      4'd7:    w_res = $signed(w_op1) >>> w_sh;
      4'd9:    w_res = w_op2;
      default: w_res = '0;
    endcase
  end

  assign w_flags = {w_v, w_c, w_res[N-1], w_res == '0};

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [SW-1:0]   r_cnt;
  logic [N-1:0]    r_mcand;
  logic [N-1:0]    r_mplier;
  logic [N-1:0]    r_prod;
  logic [N-1:0]    r_rd3;
  logic [3:0]      r_ctrl;
  logic [3*RW-1:0] r_regs;
  logic            w_start;
  logic            w_run;
  logic            w_done;

  assign w_start = (r_state == S_IDLE) && bus.validIn &&
                   (bus.aluControl == 4'd8) && !bus.flush;
  assign w_run   = (r_state == S_RUN);
  assign w_done  = (r_state == S_DONE);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_nxt = S_RUN;
      S_RUN:   if (r_cnt == SW'(N-1)) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (bus.flush) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_state <= S_IDLE;
    else if (bus.en) r_state <= w_nxt;
  end

  // shift-add: multiplicand walks left, multiplier bits walk right
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_rd3    <= '0;
      r_ctrl   <= '0;
      r_regs   <= '0;
    end else if (bus.en) begin
      if (bus.flush || w_done) begin
        r_cnt  <= '0;
        r_prod <= '0;
      end else if (w_start) begin
        r_cnt    <= '0;
        r_prod   <= '0;
        r_mcand  <= w_op1;
        r_mplier <= w_op2;
        r_ctrl   <= bus.ctrlIn;
        r_regs   <= bus.regsIn;
        r_rd3    <= bus.rd3;
      end else if (w_run) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SW'(1);
      end
    end
  end

  assign bus.busy = (r_state != S_IDLE);
`else
  assign bus.busy = 1'b0;
`endif

  logic            w_bub;
  logic            w_ld_v;
  logic [N-1:0]    w_ld_res;
  logic [3:0]      w_ld_flags;
  logic [3:0]      w_ld_ctrl;
  logic [3*RW-1:0] w_ld_regs;
  logic [N-1:0]    w_ld_rd3;

  always_comb begin
    w_bub      = bus.flush;
    w_ld_v     = bus.validIn;
    w_ld_res   = w_res;
    w_ld_flags = w_flags;
    w_ld_ctrl  = bus.ctrlIn;
    w_ld_regs  = bus.regsIn;
    w_ld_rd3   = bus.rd3;
`ifdef EXEC_MUL_EN
    if (w_done) begin
      w_ld_v     = 1'b1;
      w_ld_res   = r_prod;
      w_ld_flags = {2'b00, r_prod[N-1], r_prod == '0};
      w_ld_ctrl  = r_ctrl;
      w_ld_regs  = r_regs;
      w_ld_rd3   = r_rd3;
    end
    if (w_start || w_run) w_bub = 1'b1;
`endif
    if (w_bub) begin
      w_ld_v     = 1'b0;
      w_ld_res   = '0;
      w_ld_flags = '0;
      w_ld_ctrl  = '0;
      w_ld_regs  = '0;
      w_ld_rd3   = '0;
    end
  end

  logic            r_v;
  logic [N-1:0]    r_res;
  logic [3:0]      r_flags;
  logic [3:0]      r_xctrl;
  logic [3*RW-1:0] r_xregs;
  logic [N-1:0]    r_xrd3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v     <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
      r_xctrl <= '0;
      r_xregs <= '0;
      r_xrd3  <= '0;
    end else if (bus.en) begin
      r_v     <= w_ld_v;
      r_res   <= w_ld_res;
      r_flags <= w_ld_flags;
      r_xctrl <= w_ld_ctrl;
      r_xregs <= w_ld_regs;
      r_xrd3  <= w_ld_rd3;
    end
  end

  assign bus.exmValid  = r_v;
  assign bus.exmResult = r_res;
  assign bus.exmFlags  = r_flags;
  assign bus.exmCtrl   = r_xctrl;
  assign bus.exmRegs   = r_xregs;
  assign bus.exmRd3    = r_xrd3;
endmodule
